// File: rtl/alu_1_if.sv
// rtl/alu_1_if.sv - operand/opcode and result/flag bundle for alu_1
interface alu_1_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             inC;
  logic [2:0]       opc;
  logic [WIDTH-1:0] w;
  logic             zer;
  logic             neg;

  modport master (
    output inA, inB, inC, opc,
    input  w, zer, neg
  );

  modport slave (
    input  inA, inB, inC, opc,
    output w, zer, neg
  );
endinterface

// File: rtl/alu_1.sv
// rtl/alu_1.sv - eight-operation ALU with registered result and zero/negative flags
module alu_1 #(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  alu_1_if.slave bus
);

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] w_q;
  logic             zer_q;
  logic             neg_q;

  always_comb begin
    r_d = '0;
    unique case (bus.opc)
      3'b000: r_d = bus.inA + bus.inB + {{(WIDTH-1){1'b0}}, bus.inC};
      3'b001: r_d = bus.inA + bus.inB;
      3'b010: r_d = bus.inA - bus.inB;
      3'b011: r_d = bus.inA & bus.inB;
      3'b100: r_d = bus.inA | bus.inB;
      3'b101: r_d = bus.inA ^ bus.inB;
      3'b110: r_d = ~bus.inA;
      3'b111: r_d = {bus.inC, bus.inA[WIDTH-1:1]};
      default: r_d = '0;
    endcase
  end

  // Flags are derived from the same R as w so they can never disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q   <= '0;
      zer_q <= 1'b1;
      neg_q <= 1'b0;
    end else begin
      w_q   <= r_d;
      zer_q <= (r_d == '0);
      neg_q <= r_d[WIDTH-1];
    end
  end

  assign bus.w   = w_q;
  assign bus.zer = zer_q;
  assign bus.neg = neg_q;

endmodule

// File: tb/tb_alu_1.sv
// tb/tb_alu_1.sv - directed and randomized self-checking bench for alu_1
module tb_alu_1;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  alu_1_if #(.WIDTH(16)) bus ();

  alu_1 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic [2:0] op);
    logic [16:0] t;
    case (op)
      3'd0: t = {1'b0, a} + {1'b0, b} + {16'd0, c};
      3'd1: t = {1'b0, a} + {1'b0, b};
      3'd2: t = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd3: t = {1'b0, a & b};
      3'd4: t = {1'b0, a | b};
      3'd5: t = {1'b0, a ^ b};
      3'd6: t = {1'b0, ~a};
      default: t = {1'b0, c, a[15:1]};
    endcase
    return t[15:0];
  endfunction

  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [2:0] op);
    @(negedge clk);
    bus.inA = a;
    bus.inB = b;
    bus.inC = c;
    bus.opc = op;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.inA = 16'h1234;
    bus.inB = 16'h0001;
    bus.inC = 1'b1;
    bus.opc = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.w, bus.zer, bus.neg} !== {16'h0000, 1'b1, 1'b0})
        $display("FAIL reset_hold[%0d]: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0",
                 i, bus.w, bus.zer, bus.neg);
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'h1236, 1'b0, 1'b0})
      $display("FAIL reset_release: got w=%h zer=%b neg=%b, want w=1236 zer=0 neg=0",
               bus.w, bus.zer, bus.neg);
    else passed++;
  endtask

  task automatic test_add();
    step(16'hFFFF, 16'h0000, 1'b1, 3'b000);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL adc_wrap: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0",
               bus.w, bus.zer, bus.neg);
    else passed++;
    step(16'hFFFF, 16'h0000, 1'b1, 3'b001);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'hFFFF, 1'b0, 1'b1})
      $display("FAIL add_nocarry: got w=%h zer=%b neg=%b, want w=ffff zer=0 neg=1",
               bus.w, bus.zer, bus.neg);
    else passed++;
    step(16'h7FFF, 16'h0001, 1'b0, 3'b001);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'h8000, 1'b0, 1'b1})
      $display("FAIL add_overflow: got w=%h zer=%b neg=%b, want w=8000 zer=0 neg=1",
               bus.w, bus.zer, bus.neg);
    else passed++;
  endtask

  task automatic test_sub();
    step(16'h0005, 16'h0007, 1'b1, 3'b010);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'hFFFE, 1'b0, 1'b1})
      $display("FAIL sub_neg: got w=%h zer=%b neg=%b, want w=fffe zer=0 neg=1",
               bus.w, bus.zer, bus.neg);
    else passed++;
    step(16'h1234, 16'h1234, 1'b1, 3'b010);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL sub_zero: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0",
               bus.w, bus.zer, bus.neg);
    else passed++;
    step(16'h0000, 16'h0001, 1'b0, 3'b010);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'hFFFF, 1'b0, 1'b1})
      $display("FAIL sub_wrap: got w=%h zer=%b neg=%b, want w=ffff zer=0 neg=1",
               bus.w, bus.zer, bus.neg);
    else passed++;
  endtask

  task automatic test_logic();
    logic [2:0]  ops  [4] = '{3'b011, 3'b100, 3'b101, 3'b110};
    logic [15:0] exp_w[4] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h0F0F};
    logic [1:0]  exp_f[4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      step(16'hF0F0, 16'h3C3C, 1'b1, ops[i]);
      total++;
      if ({bus.w, bus.zer, bus.neg} !== {exp_w[i], exp_f[i]})
        $display("FAIL logic_op%0d: got w=%h zer=%b neg=%b, want w=%h zer=%b neg=%b",
                 ops[i], bus.w, bus.zer, bus.neg, exp_w[i], exp_f[i][1], exp_f[i][0]);
      else passed++;
    end
  endtask

  task automatic test_shift();
    step(16'h8001, 16'h5555, 1'b1, 3'b111);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'hC000, 1'b0, 1'b1})
      $display("FAIL shift_in1: got w=%h zer=%b neg=%b, want w=c000 zer=0 neg=1",
               bus.w, bus.zer, bus.neg);
    else passed++;
    step(16'h0001, 16'h5555, 1'b0, 3'b111);
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL shift_zero: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0",
               bus.w, bus.zer, bus.neg);
    else passed++;
    // Inputs changed between edges must not disturb the held result.
    bus.inA = 16'h00FF;
    bus.opc = 3'b110;
    #2;
    total++;
    if ({bus.w, bus.zer, bus.neg} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL hold_between_edges: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0",
               bus.w, bus.zer, bus.neg);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w;
    logic        have_exp;
    int          errs;
    have_exp = 1'b0;
    exp_w    = '0;
    errs     = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (have_exp) begin
        total++;
        if ({bus.w, bus.zer, bus.neg} !== {exp_w, exp_w == 16'h0, exp_w[15]}) begin
          if (errs < 10)
            $display("FAIL pipe[%0d]: got w=%h zer=%b neg=%b, want w=%h zer=%b neg=%b",
                     i, bus.w, bus.zer, bus.neg, exp_w, exp_w == 16'h0, exp_w[15]);
          errs++;
        end else passed++;
      end
      bus.inA  = 16'($urandom);
      bus.inB  = 16'($urandom);
      bus.inC  = 1'($urandom);
      bus.opc  = 3'(i);
      exp_w    = ref_alu(bus.inA, bus.inB, bus.inC, bus.opc);
      have_exp = 1'b1;
      if (i == 1000) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.w, bus.zer, bus.neg} !== {16'h0000, 1'b1, 1'b0})
          $display("FAIL async_reset: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0",
                   bus.w, bus.zer, bus.neg);
        else passed++;
        @(negedge clk);
        rst      = 1'b0;
        have_exp = 1'b0;
      end
    end
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    bus.inA = '0;
    bus.inB = '0;
    bus.inC = 1'b0;
    bus.opc = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
